// File: rtl/greet_glyph_dma_pkg.sv
// Shared types and constants for the greeting glyph fetch engine.
// Holds the FSM state type and the code-point to glyph-index helper.
package greet_dma_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      COMMIT = 2'd3
   } state_e;

   localparam int GREET_CP_W        = 32'd7;
   localparam int GREET_CP_START    = 32'h20;
   localparam int GREET_FONT_GLYPHS = 32'd64;
   localparam int GREET_GLYPH_W     = $clog2(GREET_FONT_GLYPHS);

   typedef struct packed {
      logic                     ok;
      logic [GREET_GLYPH_W-1:0] idx;
   } glyph_t;

   // The extra top bit of the difference catches code points below the font start.
   function automatic glyph_t cp_to_glyph(input logic [GREET_CP_W-1:0] cp,
                                          input logic [GREET_CP_W-1:0] start,
                                          input logic [GREET_CP_W:0]   n_glyphs);
      glyph_t              res;
      logic [GREET_CP_W:0] g;
      g       = {1'b0, cp} - {1'b0, start};
      res.ok  = !g[GREET_CP_W] && (g < n_glyphs);
      res.idx = g[GREET_GLYPH_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/greet_glyph_dma_if.sv
// ROM read bus between the glyph fetch engine and the greeting/font ROMs.
// Both ROMs are synchronous with one cycle of read latency.
interface greet_glyph_dma_if #(
   parameter int GREET_AW   = 32'd9,
   parameter int CP_BITS    = greet_dma_pkg::GREET_CP_W,
   parameter int FONT_AW    = 32'd9,
   parameter int FONT_WIDTH = 32'd8
);
   logic [GREET_AW-1:0]   greet_rom_addr;
   logic [CP_BITS-1:0]    greet_rom_data;
   logic [FONT_AW-1:0]    font_rom_addr;
   logic [FONT_WIDTH-1:0] font_rom_data;

   modport master (
      output greet_rom_addr,
      input  greet_rom_data,
      output font_rom_addr,
      input  font_rom_data
   );

   modport slave (
      input  greet_rom_addr,
      output greet_rom_data,
      input  font_rom_addr,
      output font_rom_data
   );
endinterface

// File: rtl/greet_glyph_dma_row_select.sv
// Decodes a screen line into text row, glyph line and an in-row flag.
// Purely combinational so sprite placement logic can reuse it directly.
module greet_row_select
   import greet_dma_pkg::*;
#(
   parameter int CORDW       = 32'd16,
   parameter int FONT_HEIGHT = 32'd8,
   parameter int SCALE_Y     = 32'd8,
   parameter int SPR_Y0      = 32'd150,
   parameter int SPR_Y1      = 32'd250,
   parameter int LINE2       = 32'd240
) (
   input  logic signed [CORDW-1:0]         sy,
   output logic                            row,
   output logic [$clog2(FONT_HEIGHT)-1:0]  gl,
   output logic                            in_range
);
   localparam int GL_W  = $clog2(FONT_HEIGHT);
   localparam int SHIFT = $clog2(SCALE_Y);
   localparam logic signed [CORDW-1:0] Y0_C     = CORDW'(SPR_Y0);
   localparam logic signed [CORDW-1:0] Y1_C     = CORDW'(SPR_Y1);
   localparam logic signed [CORDW-1:0] LINE2_C  = CORDW'(LINE2);
   localparam logic signed [CORDW-1:0] HEIGHT_C = CORDW'(FONT_HEIGHT * SCALE_Y);
   localparam logic signed [CORDW-1:0] ZERO_C   = {CORDW{1'b0}};

   logic signed [CORDW-1:0] base_s;
   logic signed [CORDW-1:0] dy_s;

   // Lines from LINE2 downward belong to the lower text row.
   always_comb begin
      row = (sy >= LINE2_C);
      if (row) begin
         base_s = Y1_C;
      end else begin
         base_s = Y0_C;
      end
      dy_s     = sy - base_s;
      in_range = (dy_s >= ZERO_C) && (dy_s < HEIGHT_C);
      gl       = GL_W'(dy_s >>> SHIFT);
   end
endmodule

// File: rtl/greet_glyph_dma.sv
// Per-line glyph fetch engine: reads one text row of code points and glyph bytes
// during blanking. Define GREET_DMA_BADCP_EN to add the badcp_cnt counter port.
module greet_glyph_dma
   import greet_dma_pkg::*;
#(
   parameter int CORDW        = 32'd16,
   parameter int SPR_CNT      = 32'd8,
   parameter int GREET_MSGS   = 32'd32,
   parameter int GREET_LENGTH = 32'd16,
   parameter int CP_W         = GREET_CP_W,
   parameter int FONT_HEIGHT  = 32'd8,
   parameter int FONT_WIDTH   = 32'd8,
   parameter int FONT_GLYPHS  = GREET_FONT_GLYPHS,
   parameter int CP_START     = GREET_CP_START,
   parameter int SCALE_Y      = 32'd8,
   parameter int SPR_Y0       = 32'd150,
   parameter int SPR_Y1       = 32'd250,
   parameter int LINE2        = 32'd240
) (
   input  logic                          clk_pix,
   input  logic                          rst_pix,
   input  logic                          line,
   input  logic signed [CORDW-1:0]       sy,
   input  logic [$clog2(GREET_MSGS)-1:0] greeting,
   greet_glyph_dma_if.master             rom,
   output logic [SPR_CNT*FONT_WIDTH-1:0] glyph_row,
   output logic                          row_active,
   output logic                          glyph_valid,
   output logic                          busy
`ifdef GREET_DMA_BADCP_EN
   ,
   output logic [7:0]                    badcp_cnt
`endif
);
   localparam int GREET_AW = $clog2(GREET_MSGS * GREET_LENGTH);
   localparam int FONT_AW  = $clog2(FONT_GLYPHS * FONT_HEIGHT);
   localparam int GL_W     = $clog2(FONT_HEIGHT);
   localparam int K_W      = $clog2(SPR_CNT);

   state_e                        state_r, state_s;
   logic [K_W-1:0]                k_r, cp_k_r, fd_k_r;
   logic                          drain_r, in_range_r;
   logic [GL_W-1:0]               gl_r;
   logic [GREET_AW-1:0]           greet_addr_r, greet_base_s;
   logic                          cp_v_r, fd_v_r, fd_ok_r;
   logic [SPR_CNT*FONT_WIDTH-1:0] staging_r, glyph_row_r;
   logic                          row_active_r, glyph_valid_r, busy_r;
   logic [FONT_AW-1:0]            font_addr_s;
   logic [CP_W-1:0]               cp_s;
   glyph_t                        glyph_s;
   logic                          sel_row_s, sel_in_range_s;
   logic [GL_W-1:0]               sel_gl_s;

   greet_row_select #(
      .CORDW       (CORDW),
      .FONT_HEIGHT (FONT_HEIGHT),
      .SCALE_Y     (SCALE_Y),
      .SPR_Y0      (SPR_Y0),
      .SPR_Y1      (SPR_Y1),
      .LINE2       (LINE2)
   ) u_row_select (
      .sy       (sy),
      .row      (sel_row_s),
      .gl       (sel_gl_s),
      .in_range (sel_in_range_s)
   );

   assign cp_s    = rom.greet_rom_data;
   assign glyph_s = cp_to_glyph(cp_s, GREET_CP_W'(CP_START), (GREET_CP_W + 1)'(FONT_GLYPHS));

   // State register; busy follows the upcoming state so it is a clean flop output.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
      end
   end

   // Next-state decode; a line pulse is only honoured in IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (line && sel_in_range_s) begin
               state_s = FETCH;
            end else if (line) begin
               state_s = COMMIT;
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            if (k_r == K_W'(SPR_CNT - 1)) begin
               state_s = DRAIN;
            end else begin
               state_s = FETCH;
            end
         end
         DRAIN: begin
            if (drain_r) begin
               state_s = COMMIT;
            end else begin
               state_s = DRAIN;
            end
         end
         COMMIT:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // First greeting ROM address of the selected message half.
   always_comb begin
      if (sel_row_s) begin
         greet_base_s = GREET_AW'(greeting) * GREET_AW'(GREET_LENGTH) + GREET_AW'(GREET_LENGTH / 2);
      end else begin
         greet_base_s = GREET_AW'(greeting) * GREET_AW'(GREET_LENGTH);
      end
   end

   // Font address follows the returning code point in the same cycle; blanks read address 0.
   always_comb begin
      if (cp_v_r && glyph_s.ok) begin
         font_addr_s = FONT_AW'(glyph_s.idx) * FONT_AW'(FONT_HEIGHT) + FONT_AW'(gl_r);
      end else begin
         font_addr_s = {FONT_AW{1'b0}};
      end
   end

   // Fetch pipeline, staging buffer and atomic commit of the visible row.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         k_r           <= {K_W{1'b0}};
         drain_r       <= 1'b0;
         gl_r          <= {GL_W{1'b0}};
         in_range_r    <= 1'b0;
         greet_addr_r  <= {GREET_AW{1'b0}};
         cp_v_r        <= 1'b0;
         cp_k_r        <= {K_W{1'b0}};
         fd_v_r        <= 1'b0;
         fd_k_r        <= {K_W{1'b0}};
         fd_ok_r       <= 1'b0;
         staging_r     <= {(SPR_CNT * FONT_WIDTH){1'b0}};
         glyph_row_r   <= {(SPR_CNT * FONT_WIDTH){1'b0}};
         row_active_r  <= 1'b0;
         glyph_valid_r <= 1'b0;
      end else begin
         cp_v_r        <= (state_r == FETCH);
         cp_k_r        <= k_r;
         fd_v_r        <= cp_v_r;
         fd_k_r        <= cp_k_r;
         fd_ok_r       <= glyph_s.ok;
         glyph_valid_r <= 1'b0;
         if (fd_v_r) begin
            staging_r[fd_k_r * FONT_WIDTH +: FONT_WIDTH] <= fd_ok_r ? rom.font_rom_data : {FONT_WIDTH{1'b0}};
         end
         case (state_r)
            IDLE: begin
               if (line) begin
                  gl_r         <= sel_gl_s;
                  in_range_r   <= sel_in_range_s;
                  k_r          <= {K_W{1'b0}};
                  drain_r      <= 1'b0;
                  greet_addr_r <= sel_in_range_s ? greet_base_s : {GREET_AW{1'b0}};
               end
            end
            FETCH: begin
               k_r <= k_r + K_W'(1);
               if (k_r == K_W'(SPR_CNT - 1)) begin
                  greet_addr_r <= {GREET_AW{1'b0}};
               end else begin
                  greet_addr_r <= greet_addr_r + GREET_AW'(1);
               end
            end
            DRAIN: drain_r <= 1'b1;
            COMMIT: begin
               glyph_row_r   <= in_range_r ? staging_r : {(SPR_CNT * FONT_WIDTH){1'b0}};
               row_active_r  <= in_range_r;
               glyph_valid_r <= 1'b1;
            end
            default: drain_r <= 1'b0;
         endcase
      end
   end

`ifdef GREET_DMA_BADCP_EN
   logic [7:0] badcp_r;

   // Saturating tally of code points that have no glyph.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         badcp_r <= 8'd0;
      end else if (cp_v_r && !glyph_s.ok && (badcp_r != 8'hFF)) begin
         badcp_r <= badcp_r + 8'd1;
      end
   end

   assign badcp_cnt = badcp_r;
`endif

   assign rom.greet_rom_addr = greet_addr_r;
   assign rom.font_rom_addr  = font_addr_s;
   assign glyph_row          = glyph_row_r;
   assign row_active         = row_active_r;
   assign glyph_valid        = glyph_valid_r;
   assign busy               = busy_r;
endmodule

// File: tb/tb_greet_glyph_dma.sv
// Directed bench for greet_glyph_dma with behavioural greeting and font ROMs.
module tb_greet_glyph_dma;
   logic               clk_pix = 1'b0;
   logic               rst_pix;
   logic               line;
   logic signed [15:0] sy;
   logic [4:0]         greeting;
   logic [63:0]        glyph_row;
   logic               row_active, glyph_valid, busy;
`ifdef GREET_DMA_BADCP_EN
   logic [7:0]         badcp_cnt;
   logic [7:0]         badcp_before;
`endif
   logic [6:0]         greet_mem [512];
   logic [8:0]         addr_log [16];
   int                 pass_cnt = 0;
   int                 total_cnt = 0;
   int                 lat;
   int                 vcnt;

   greet_glyph_dma_if rom_bus ();

   greet_glyph_dma dut (
      .clk_pix     (clk_pix),
      .rst_pix     (rst_pix),
      .line        (line),
      .sy          (sy),
      .greeting    (greeting),
      .rom         (rom_bus),
      .glyph_row   (glyph_row),
      .row_active  (row_active),
      .glyph_valid (glyph_valid),
      .busy        (busy)
`ifdef GREET_DMA_BADCP_EN
      ,
      .badcp_cnt   (badcp_cnt)
`endif
   );

   always #5 clk_pix = ~clk_pix;

   function automatic logic [7:0] font_byte(input logic [8:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   always @(posedge clk_pix) begin
      rom_bus.greet_rom_data <= greet_mem[rom_bus.greet_rom_addr];
      rom_bus.font_rom_data  <= font_byte(rom_bus.font_rom_addr);
   end

   function automatic logic [63:0] exp_row(input int msg, input int r, input int gl);
      logic [63:0] res;
      logic [6:0]  cp;
      res = 64'd0;
      for (int k = 0; k < 8; k++) begin
         cp = greet_mem[msg * 16 + r * 8 + k];
         if (cp >= 7'h20 && cp < 7'h60) res[k * 8 +: 8] = font_byte(9'((int'(cp) - 32) * 8 + gl));
      end
      return res;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Pulse line for one cycle; lat = edges until glyph_valid is seen, -1 on timeout.
   task automatic run_line(input logic signed [15:0] y, input logic [4:0] g, output int n_out);
      @(posedge clk_pix); #1;
      sy = y; greeting = g; line = 1'b1;
      n_out = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_pix); #1;
         line = 1'b0;
         if (n <= 16) addr_log[n - 1] = rom_bus.greet_rom_addr;
         if (glyph_valid) begin
            n_out = n;
            break;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) greet_mem[i] = 7'h20 + 7'(i % 64);
      greet_mem[0] = 7'h48; greet_mem[1] = 7'h45; greet_mem[2] = 7'h4C; greet_mem[3] = 7'h4C;
      greet_mem[4] = 7'h4F; greet_mem[5] = 7'h20; greet_mem[6] = 7'h41; greet_mem[7] = 7'h42;
      greet_mem[18] = 7'h1F;
      greet_mem[21] = 7'h60;
      rst_pix = 1'b1; line = 1'b0; sy = 16'sd0; greeting = 5'd0;
      repeat (3) @(posedge clk_pix);
      #1;
      check("rst_glyph_row", glyph_row, 64'd0);
      check("rst_row_active", 64'(row_active), 64'd0);
      check("rst_glyph_valid", 64'(glyph_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_greet_addr", 64'(rom_bus.greet_rom_addr), 64'd0);
      check("rst_font_addr", 64'(rom_bus.font_rom_addr), 64'd0);
      rst_pix = 1'b0;

      run_line(16'sd150, 5'd0, lat);
      check("hello_latency", 64'(lat), 64'd12);
      check("hello_row_active", 64'(row_active), 64'd1);
      check("hello_slot0", 64'(glyph_row[7:0]), 64'hE5);
      check("hello_row", glyph_row, exp_row(0, 0, 0));
      @(posedge clk_pix); #1;
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_valid_pulse", 64'(glyph_valid), 64'd0);
      check("idle_greet_addr", 64'(rom_bus.greet_rom_addr), 64'd0);
      check("idle_font_addr", 64'(rom_bus.font_rom_addr), 64'd0);

      run_line(16'sd257, 5'd3, lat);
      check("row1_latency", 64'(lat), 64'd12);
      for (int k = 0; k < 8; k++) check($sformatf("row1_addr%0d", k), 64'(addr_log[k]), 64'(56 + k));
      check("row1_row", glyph_row, exp_row(3, 1, 0));

      run_line(16'sd213, 5'd0, lat);
      check("gl7_latency", 64'(lat), 64'd12);
      check("gl7_row_active", 64'(row_active), 64'd1);
      check("gl7_row", glyph_row, exp_row(0, 0, 7));

      run_line(16'sd214, 5'd0, lat);
      check("below_latency", 64'(lat), 64'd2);
      check("below_row_active", 64'(row_active), 64'd0);
      check("below_glyph_row", glyph_row, 64'd0);

      run_line(16'sd149, 5'd0, lat);
      check("above_latency", 64'(lat), 64'd2);
      check("above_row_active", 64'(row_active), 64'd0);

`ifdef GREET_DMA_BADCP_EN
      badcp_before = badcp_cnt;
`endif
      run_line(16'sd150, 5'd1, lat);
      check("badcp_latency", 64'(lat), 64'd12);
      check("badcp_slot2", 64'(glyph_row[23:16]), 64'd0);
      check("badcp_slot5", 64'(glyph_row[47:40]), 64'd0);
      check("badcp_row", glyph_row, exp_row(1, 0, 0));
`ifdef GREET_DMA_BADCP_EN
      check("badcp_count", 64'(badcp_cnt), 64'(badcp_before + 8'd2));
`endif

      // Second pulse while busy and a greeting change mid-fetch must both be ignored.
      @(posedge clk_pix); #1;
      sy = 16'sd150; greeting = 5'd0; line = 1'b1;
      vcnt = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_pix); #1;
         line = (n == 3);
         if (n == 2) greeting = 5'd5;
         if (glyph_valid) vcnt++;
      end
      check("busy_line_valids", 64'(vcnt), 64'd1);
      check("latched_greeting_row", glyph_row, exp_row(0, 0, 0));

      // Reset in the middle of a fetch.
      @(posedge clk_pix); #1;
      sy = 16'sd160; greeting = 5'd2; line = 1'b1;
      repeat (4) begin
         @(posedge clk_pix); #1;
         line = 1'b0;
      end
      check("midfetch_busy", 64'(busy), 64'd1);
      rst_pix = 1'b1;
      @(posedge clk_pix); #1;
      rst_pix = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_glyph_row", glyph_row, 64'd0);
      check("midrst_row_active", 64'(row_active), 64'd0);
      check("midrst_greet_addr", 64'(rom_bus.greet_rom_addr), 64'd0);
      vcnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk_pix); #1;
         if (glyph_valid) vcnt++;
      end
      check("midrst_no_valid", 64'(vcnt), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
